// File: rtl/wtb_pkg.sv
// Shared wavetable definitions used by the load sequencer, the wavetable
// loader and the synthesis top.
//   WTB_NUM_W   : width of a wavetable number
//   WTB_COUNT   : number of addressable wavetables
//   seq_state_e : load-sequencer FSM state encoding
package wtb_pkg;

    localparam int WTB_NUM_W = 5;
    localparam int WTB_COUNT = 32;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_ERROR = 2'd3
    } seq_state_e;

endpackage

// File: rtl/wtb_timeout_timer.sv
// Cycle timer for the load handshake. Cleared when a request is issued,
// counts while the sequencer waits, flags terminal count at TIMEOUT-1.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear (takes priority over en)
//   en       : count enable
//   tc       : count == TIMEOUT-1
module wtb_timeout_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/wtb_load_sequencer.sv
// Initiator side of the wavetable-load handshake. A start pulse walks tables
// FIRST_WTB..LAST_WTB: each is requested with a one-cycle wtb_load pulse, then
// the matching completion is awaited. A silent loader triggers a re-issue
// after TIMEOUT cycles, up to MAX_RETRY times, after which the run aborts.
// The voice stays muted until every table in the range has loaded.
//   start                       : run request (ignored while busy)
//   wtb_load, wtb_num           : load request pulse and table number
//   wtb_load_done, wtb_load_num : loader completion strobe and its table
//   busy, done, error           : run status (done/error sticky until start)
//   err_wtb_num                 : table that exhausted its retries
//   loaded_count                : tables loaded in the current/last run
//   voice_mute                  : ~done
module wtb_load_sequencer
    import wtb_pkg::*;
#(
    parameter int FIRST_WTB = 0,
    parameter int LAST_WTB  = 31,
    parameter int TIMEOUT   = 4096,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       wtb_load,
    output logic [4:0] wtb_num,
    input  logic [4:0] wtb_load_num,
    input  logic       wtb_load_done,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] err_wtb_num,
    output logic [5:0] loaded_count,
    output logic       voice_mute
);

    if (FIRST_WTB < 0 || FIRST_WTB > LAST_WTB || LAST_WTB > WTB_COUNT - 1) begin : g_bad_range
        $error("wtb_load_sequencer: need 0 <= FIRST_WTB <= LAST_WTB <= 31");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wtb_load_sequencer: TIMEOUT must be >= 2");
    end

    // +2 keeps the width non-zero when MAX_RETRY is 0
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0]   MAX_RETRY_C = RETRY_W'(MAX_RETRY);
    localparam logic [WTB_NUM_W-1:0] FIRST_C     = WTB_NUM_W'(FIRST_WTB);
    localparam logic [WTB_NUM_W-1:0] LAST_C      = WTB_NUM_W'(LAST_WTB);
    localparam logic [5:0]           TABLES_C    = 6'(LAST_WTB - FIRST_WTB + 1);

    seq_state_e           state_q, state_d;
    logic [WTB_NUM_W-1:0] cur_q, cur_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [WTB_NUM_W-1:0] err_num_q, err_num_d;
    logic [5:0]           cnt_q, cnt_d;

    logic tmr_tc;
    logic accept;
    logic retry_left;

    wtb_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (state_q == SEQ_ISSUE),
        .en  (state_q == SEQ_WAIT),
        .tc  (tmr_tc)
    );

    // Only a completion naming the pending table counts; strays are dropped
    // and leave the timer running.
    assign accept     = (state_q == SEQ_WAIT) && wtb_load_done && (wtb_load_num == cur_q);
    assign retry_left = (retry_q < MAX_RETRY_C);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SEQ_IDLE;
            cur_q     <= FIRST_C;
            retry_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_num_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            retry_q   <= retry_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_num_q <= err_num_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state; a completion in the timeout cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:  if (start) state_d = SEQ_ISSUE;
            SEQ_ISSUE: state_d = SEQ_WAIT;
            SEQ_WAIT: begin
                if (accept)
                    state_d = (cur_q == LAST_C) ? SEQ_IDLE : SEQ_ISSUE;
                else if (tmr_tc)
                    state_d = retry_left ? SEQ_ISSUE : SEQ_ERROR;
            end
            SEQ_ERROR: state_d = SEQ_IDLE;
            default:   state_d = SEQ_IDLE;
        endcase
    end

    // Run bookkeeping
    always_comb begin
        cur_d     = cur_q;
        retry_d   = retry_q;
        done_d    = done_q;
        error_d   = error_q;
        err_num_d = err_num_q;
        cnt_d     = cnt_q;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    cur_d   = FIRST_C;
                    retry_d = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            SEQ_WAIT: begin
                if (accept) begin
                    retry_d = '0;
                    if (cnt_q < TABLES_C)
                        cnt_d = cnt_q + 6'd1;
                    if (cur_q == LAST_C)
                        done_d = 1'b1;
                    else
                        cur_d = cur_q + 1'b1;
                end else if (tmr_tc && retry_left) begin
                    retry_d = retry_q + 1'b1;
                end
            end
            SEQ_ERROR: begin
                error_d   = 1'b1;
                err_num_d = cur_q;
            end
            default: ;
        endcase
    end

    // Outputs: registers or decodes of the state register only
    always_comb begin
        wtb_load     = (state_q == SEQ_ISSUE);
        busy         = (state_q != SEQ_IDLE);
        wtb_num      = cur_q;
        done         = done_q;
        error        = error_q;
        err_wtb_num  = err_num_q;
        loaded_count = cnt_q;
        voice_mute   = ~done_q;
    end

endmodule
